// File: rtl/fru_pkg.sv
// fru_pkg
// Shared types and default sizes for the filter-override controller.
//   fru_state_e      : controller state encoding
//   FRU_FILTER_SIZE  : default lane count of the signal filter unit
//   FRU_TIMER_W      : default width of the override-duration counter
package fru_pkg;

  localparam int FRU_FILTER_SIZE = 10;
  localparam int FRU_TIMER_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_RELEASE = 2'd3
  } fru_state_e;

endpackage

// File: rtl/fru_override_timer.sv
// fru_override_timer
// Down-counter that bounds the length of an override.
//   clk, rst_n : block clock, async active-low reset (count cleared)
//   load       : load load_val (takes priority over en)
//   load_val   : override length in cycles
//   en         : decrement this cycle
//   expire     : high during the last counted cycle (count == 1)
// A loaded value of 0 never expires: the count stays parked at 0.
module fru_override_timer
  import fru_pkg::*;
#(
  parameter int TIMER_W = FRU_TIMER_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               en,
  output logic               expire
);

  logic [TIMER_W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == TIMER_W'(1));

endmodule

// File: rtl/fru_filter_ctrl.sv
// fru_filter_ctrl
// Stages a per-lane override (bypass mask + constant) for the signal filter
// unit and applies it on Trigger until Abort or, when built with
// FRU_FILTER_TIMEOUT_EN, until the staged duration runs out.
//   clk, rst_n            : block clock, async active-low reset
//   CfgValid / CfgReady   : configuration handshake (ready only in IDLE)
//   CfgBypass, CfgConst   : lane mask / constant to stage
//   CfgDuration           : override length, 0 = hold until Abort
//                           (ignored unless FRU_FILTER_TIMEOUT_EN)
//   Trigger, Abort        : start / cancel the override (Abort wins)
//   BypassEn, RegConst    : registered drive to the filter unit
//   Active                : override currently applied
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | no override staged, accepting configuration
// ARMED   | configuration staged, waiting for Trigger or Abort
// ACTIVE  | override applied to the filter lanes
// RELEASE | one cycle with outputs cleared, then back to IDLE
module fru_filter_ctrl
  import fru_pkg::*;
#(
  parameter int FILTER_SIZE = FRU_FILTER_SIZE,
  parameter int TIMER_W     = FRU_TIMER_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   CfgValid,
  output logic                   CfgReady,
  input  logic [FILTER_SIZE-1:0] CfgBypass,
  input  logic [FILTER_SIZE-1:0] CfgConst,
  input  logic [TIMER_W-1:0]     CfgDuration,
  input  logic                   Trigger,
  input  logic                   Abort,
  output logic [FILTER_SIZE-1:0] BypassEn,
  output logic [FILTER_SIZE-1:0] RegConst,
  output logic                   Active
);

  fru_state_e             state_d, state_q;
  logic [FILTER_SIZE-1:0] sh_byp_d, sh_byp_q;
  logic [FILTER_SIZE-1:0] sh_const_d, sh_const_q;
  logic [FILTER_SIZE-1:0] byp_d, byp_q;
  logic [FILTER_SIZE-1:0] const_d, const_q;
  logic                   active_d, active_q;
  logic                   handshake;
  logic                   timer_load;
  logic                   timer_expire;

  assign handshake = (state_q == ST_IDLE) && CfgValid;

`ifdef FRU_FILTER_TIMEOUT_EN
  logic [TIMER_W-1:0] sh_dur_d, sh_dur_q;

  assign sh_dur_d = handshake ? CfgDuration : sh_dur_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_dur_q <= '0;
    end else begin
      sh_dur_q <= sh_dur_d;
    end
  end

  fru_override_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (sh_dur_q),
    .en       (state_q == ST_ACTIVE),
    .expire   (timer_expire)
  );
`else
  // CfgDuration has no effect in this build; only Abort ends an override.
  logic unused_cfg_duration;
  assign unused_cfg_duration = ^{CfgDuration, timer_load};
  assign timer_expire        = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    sh_byp_d   = sh_byp_q;
    sh_const_d = sh_const_q;
    byp_d      = byp_q;
    const_d    = const_q;
    active_d   = active_q;
    timer_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        byp_d    = '0;
        const_d  = '0;
        active_d = 1'b0;
        if (handshake) begin
          sh_byp_d   = CfgBypass;
          sh_const_d = CfgConst;
          state_d    = ST_ARMED;
        end
      end
      ST_ARMED: begin
        byp_d    = '0;
        const_d  = '0;
        active_d = 1'b0;
        if (Abort) begin
          state_d = ST_RELEASE;
        end else if (Trigger) begin
          // Outputs load on the same edge the state enters ACTIVE.
          state_d    = ST_ACTIVE;
          byp_d      = sh_byp_q;
          const_d    = sh_const_q;
          active_d   = 1'b1;
          timer_load = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (Abort || timer_expire) begin
          state_d  = ST_RELEASE;
          byp_d    = '0;
          const_d  = '0;
          active_d = 1'b0;
        end
      end
      ST_RELEASE: begin
        state_d  = ST_IDLE;
        byp_d    = '0;
        const_d  = '0;
        active_d = 1'b0;
      end
      default: begin
        state_d  = ST_IDLE;
        byp_d    = '0;
        const_d  = '0;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sh_byp_q   <= '0;
      sh_const_q <= '0;
      byp_q      <= '0;
      const_q    <= '0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_byp_q   <= sh_byp_d;
      sh_const_q <= sh_const_d;
      byp_q      <= byp_d;
      const_q    <= const_d;
      active_q   <= active_d;
    end
  end

  assign CfgReady = (state_q == ST_IDLE);
  assign BypassEn = byp_q;
  assign RegConst = const_q;
  assign Active   = active_q;

endmodule

// File: tb/tb_fru_filter_ctrl.sv
// tb_fru_filter_ctrl
// Self-checking bench for fru_filter_ctrl. Each override is predicted from
// its configuration alone: the number of ACTIVE cycles is the smaller of
// the Abort point and (timeout build, nonzero duration) the duration; it is
// followed by one cleared RELEASE cycle and then IDLE. Inputs are driven and
// outputs sampled on the falling edge.
module tb_fru_filter_ctrl;

  localparam int FS = 10;
  localparam int TW = 16;
`ifdef FRU_FILTER_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          CfgValid = 1'b0;
  logic          CfgReady;
  logic [FS-1:0] CfgBypass = '0;
  logic [FS-1:0] CfgConst = '0;
  logic [TW-1:0] CfgDuration = '0;
  logic          Trigger = 1'b0;
  logic          Abort = 1'b0;
  logic [FS-1:0] BypassEn;
  logic [FS-1:0] RegConst;
  logic          Active;

  int checks = 0;
  int errors = 0;

  // Configuration that will be held on the interface during the next
  // override (stall check) and then used for the following run.
  logic [FS-1:0] nb, nc;
  logic [TW-1:0] nd;

  always #5 clk = ~clk;

  fru_filter_ctrl #(
    .FILTER_SIZE (FS),
    .TIMER_W     (TW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .CfgValid    (CfgValid),
    .CfgReady    (CfgReady),
    .CfgBypass   (CfgBypass),
    .CfgConst    (CfgConst),
    .CfgDuration (CfgDuration),
    .Trigger     (Trigger),
    .Abort       (Abort),
    .BypassEn    (BypassEn),
    .RegConst    (RegConst),
    .Active      (Active)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag, input logic ready);
    chk({tag, "_ready"}, 32'(CfgReady), 32'(ready));
    chk({tag, "_active"}, 32'(Active), 32'd0);
    chk({tag, "_byp"}, 32'(BypassEn), 32'd0);
    chk({tag, "_const"}, 32'(RegConst), 32'd0);
  endtask

  // One complete override from IDLE back to IDLE.
  //   abort_at : Abort is raised during this ACTIVE cycle (1-based)
  //   same     : Trigger and Abort together in ARMED
  //   hold     : keep CfgValid high with {nb,nc,nd} from ACTIVE onward
  task automatic run(input logic [FS-1:0] byp, input logic [FS-1:0] cst,
                     input logic [TW-1:0] dur, input int abort_at,
                     input bit same, input bit hold);
    int tl;
    int len;
    int nwait;
    chk_quiet("idle", 1'b1);
    CfgValid    = 1'b1;
    CfgBypass   = byp;
    CfgConst    = cst;
    CfgDuration = dur;
    @(negedge clk);
    CfgValid    = 1'b0;
    CfgBypass   = FS'($urandom);
    CfgConst    = FS'($urandom);
    CfgDuration = TW'($urandom);
    chk_quiet("armed", 1'b0);
    nwait = $urandom_range(0, 2);
    for (int w = 0; w < nwait; w++) begin
      @(negedge clk);
      chk_quiet("armed_wait", 1'b0);
    end
    Trigger = 1'b1;
    Abort   = same;
    @(negedge clk);
    Trigger = 1'b0;
    Abort   = 1'b0;
    tl  = (TIMEOUT && dur != '0) ? int'(dur) : (1 << 30);
    len = same ? 0 : ((abort_at < tl) ? abort_at : tl);
    for (int k = 1; k <= len; k++) begin
      chk("act_active", 32'(Active), 32'd1);
      chk("act_byp", 32'(BypassEn), 32'(byp));
      chk("act_const", 32'(RegConst), 32'(cst));
      chk("act_ready", 32'(CfgReady), 32'd0);
      if (hold) begin
        CfgValid    = 1'b1;
        CfgBypass   = nb;
        CfgConst    = nc;
        CfgDuration = nd;
      end
      Trigger = 1'($urandom_range(0, 1));
      Abort   = (k == abort_at);
      @(negedge clk);
      Trigger = 1'b0;
      Abort   = 1'b0;
    end
    chk_quiet("release", 1'b0);
    Trigger = 1'($urandom_range(0, 1));
    @(negedge clk);
    Trigger = 1'b0;
  endtask

  initial begin
    logic [FS-1:0] cb, cc;
    logic [TW-1:0] cd;
    bit            h;

    repeat (2) @(negedge clk);
    chk_quiet("in_reset", 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    chk_quiet("after_reset", 1'b1);

    // Trigger and Abort in IDLE do nothing.
    Trigger = 1'b1;
    @(negedge clk);
    Trigger = 1'b0;
    Abort   = 1'b1;
    @(negedge clk);
    Abort   = 1'b0;
    chk_quiet("idle_ignore", 1'b1);

    // 5/4/3: three ACTIVE cycles with the timer, Abort after 100 without.
    run(10'h005, 10'h004, 16'd3, 100, 1'b0, 1'b0);

    // Trigger together with Abort in ARMED: straight to RELEASE.
    run(FS'($urandom), FS'($urandom), 16'd2, 1, 1'b1, 1'b0);

`ifdef FRU_FILTER_TIMEOUT_EN
    run(FS'($urandom), FS'($urandom), 16'd0, 1000, 1'b0, 1'b0);
`else
    run(FS'($urandom), FS'($urandom), 16'd5, 12, 1'b0, 1'b0);
`endif

    // Config held during ACTIVE is stalled, then taken in IDLE.
    nb = FS'($urandom);
    nc = FS'($urandom);
    nd = 16'd2;
    run(FS'($urandom), FS'($urandom), 16'd4, 3, 1'b0, 1'b1);
    chk("held_ready", 32'(CfgReady), 32'd1);
    run(nb, nc, nd, 2, 1'b0, 1'b0);

    // Randomized overrides.
    cb = FS'($urandom);
    cc = FS'($urandom);
    cd = TW'($urandom_range(0, 6));
    for (int i = 0; i < 10; i++) begin
      nb = FS'($urandom);
      nc = FS'($urandom);
      nd = TW'($urandom_range(0, 6));
      h  = (i < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
      run(cb, cc, cd, $urandom_range(1, 8), ($urandom_range(0, 7) == 0), h);
      cb = nb;
      cc = nc;
      cd = nd;
    end
    CfgValid = 1'b0;

    // Asynchronous reset in the middle of an override.
    CfgValid    = 1'b1;
    CfgBypass   = 10'h3FF;
    CfgConst    = FS'($urandom);
    CfgDuration = 16'd0;
    @(negedge clk);
    CfgValid = 1'b0;
    Trigger  = 1'b1;
    @(negedge clk);
    Trigger = 1'b0;
    chk("pre_rst_active", 32'(Active), 32'd1);
    chk("pre_rst_byp", 32'(BypassEn), 32'h3FF);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_active", 32'(Active), 32'd0);
    chk("rst_byp", 32'(BypassEn), 32'd0);
    chk("rst_const", 32'(RegConst), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(CfgReady), 32'd1);
    @(negedge clk);
    run(FS'($urandom), FS'($urandom), 16'd1, 4, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fru_filter_ctrl.md
FRU_FILTER_CTRL -- requirements
Module: fru_filter_ctrl

Interface
REQ-001 Parameter FILTER_SIZE, default 10, width of the filter lanes it drives.
REQ-002 Parameter TIMER_W, default 16, width of the override-duration counter.
REQ-003 clk  input  1  single block clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 CfgValid  input  1  configuration request valid.
REQ-006 CfgReady  output  1  controller accepts configuration this cycle.
REQ-007 CfgBypass  input  FILTER_SIZE  per-lane override mask to stage.
REQ-008 CfgConst  input  FILTER_SIZE  per-lane constant values to stage.
REQ-009 CfgDuration  input  TIMER_W  override length in cycles; 0 means hold until Abort.
REQ-010 Trigger  input  1  start the staged override.
REQ-011 Abort  input  1  cancel the staged or active override.
REQ-012 BypassEn  output  FILTER_SIZE  registered select to the signal filter unit.
REQ-013 RegConst  output  FILTER_SIZE  registered constant to the signal filter unit.
REQ-014 Active  output  1  high while the override is applied.

Function
REQ-015 FSM states SHALL be IDLE, ARMED, ACTIVE, RELEASE.
REQ-016 CfgReady SHALL be 1 only in IDLE; handshake occurs on CfgValid & CfgReady at a rising edge.
REQ-017 On handshake, CfgBypass/CfgConst/CfgDuration SHALL be latched into shadow registers and the FSM SHALL enter ARMED next cycle.
REQ-018 In ARMED, Trigger without Abort SHALL move to ACTIVE; BypassEn/RegConst SHALL take the shadow values on the same edge (one-cycle latency from Trigger to outputs).
REQ-019 In ACTIVE, Active=1 and BypassEn/RegConst SHALL hold the shadow values unchanged.
REQ-020 In ARMED or ACTIVE, Abort SHALL move to RELEASE next edge; Abort has priority over Trigger in the same cycle.
REQ-021 RELEASE SHALL last exactly one cycle, drive BypassEn=0, RegConst=0, Active=0, then return to IDLE.
REQ-022 In IDLE and ARMED, BypassEn, RegConst and Active SHALL be 0.
REQ-023 Trigger in IDLE, RELEASE or ACTIVE SHALL be ignored; CfgValid outside IDLE SHALL stall (no capture).
REQ-024 Shadow registers SHALL be written only on handshake; ACTIVE never sees a mid-override config change.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, BypassEn=0, RegConst=0, Active=0, CfgReady=1 after deassertion, shadows and counter to 0.
REQ-026 Reset asserted during ACTIVE SHALL drop the override asynchronously without passing through RELEASE.

Configuration
REQ-027 Macro FRU_FILTER_TIMEOUT_EN SHALL compile in the duration counter.
REQ-028 With the macro: on entry to ACTIVE, counter loads CfgDuration shadow; it decrements each ACTIVE cycle; when counter==1 the FSM enters RELEASE next edge, giving exactly N ACTIVE cycles for N>=1; N=0 holds until Abort.
REQ-029 Without the macro: no counter exists, CfgDuration is ignored, ACTIVE persists until Abort.

Structure
REQ-030 Shared package fru_pkg SHALL hold the state enum type and default FILTER_SIZE / TIMER_W constants.
REQ-031 The duration counter SHALL be a sub-module fru_override_timer (load, enable, expire), instantiated only under FRU_FILTER_TIMEOUT_EN.

Verification
REQ-032 Reset mid-ACTIVE with BypassEn=10'h3FF -> outputs 0 immediately, CfgReady=1 after rst_n rises.
REQ-033 Config Bypass=10'h005, Const=10'h004, Duration=3, Trigger -> outputs appear one cycle later, Active high exactly 3 cycles, one RELEASE cycle, back in IDLE.
REQ-034 Duration=0 with macro, Trigger, wait 1000 cycles, Abort -> Active high throughout, RELEASE then IDLE.
REQ-035 Trigger and Abort asserted together in ARMED -> no ACTIVE cycle, RELEASE then IDLE.
REQ-036 CfgValid held high with new data during ACTIVE -> CfgReady=0, outputs unchanged; new config captured only after return to IDLE.
REQ-037 Build without macro, Duration=5 -> Active remains high past 5 cycles until Abort.
